// File: rtl/dmem_io_pkg.sv
// Shared decode constants, IO word offsets and UART state encoding for the
// memory-stage bridge and its UART transmitter.
package dmem_io_pkg;

  // Any address bit set under this mask falls outside the 4 KB RAM window.
  localparam logic [31:0] RAM_HI_MASK = 32'hFFFF_F000;

  // Upper 24 address bits that select the IO block.
  localparam logic [23:0] IO_BASE = 24'hFFFFFF;

  // IO register word offsets (OpResult[7:2]).
  localparam logic [5:0] OFF_LED       = 6'h00;
  localparam logic [5:0] OFF_CYCLE     = 6'h01;
  localparam logic [5:0] OFF_UART_DATA = 6'h02;
  localparam logic [5:0] OFF_UART_STAT = 6'h03;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a registered, glitch-free serial output.
//
// state | meaning
// IDLE  | line high, waiting for start
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high) for CLKS_PER_BIT cycles, then IDLE
module uart_tx
  import dmem_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

  uart_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_cnt_tc;

  assign w_cnt_tc = (r_cnt == '0);

  // Next-state logic; the line level is computed for the next state so that
  // the registered output changes on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_tx_nxt    = r_tx;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (start) begin
          w_state_nxt = START;
          w_cnt_nxt   = CNT_LOAD;
          w_idx_nxt   = 3'd0;
          w_data_nxt  = data;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_cnt_tc) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = CNT_LOAD;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = r_data[0];
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DATA: begin
        if (w_cnt_tc) begin
          w_cnt_nxt = CNT_LOAD;
          if (r_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_tx_nxt  = r_data[r_idx + 3'd1];
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      STOP: begin
        if (w_cnt_tc) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // State, bit timer, bit index, latched byte and line register.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_data  <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != IDLE);

endmodule

// File: rtl/dmem_io_bridge.sv
// Memory-stage slave: data RAM, LED register, free-running cycle counter and
// UART transmitter behind a single word-access load/store port.
module dmem_io_bridge
  import dmem_io_pkg::*;
#(
  parameter int DMEM_AW      = 10,
  parameter int LED_W        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             MemWrite,
  input  logic [31:0]      OpResult,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] LED,
  output logic             UART_TX
);

  logic [31:0]        r_mem [2**DMEM_AW];
  logic [LED_W-1:0]   r_led;
  logic [31:0]        r_cycle;
  logic               r_ovr;

  logic               w_ram_hit;
  logic               w_io_hit;
  logic [DMEM_AW-1:0] w_ram_idx;
  logic [5:0]         w_off;
  logic               w_busy;
  logic               w_wr_io;
  logic               w_wr_uart;
  logic               w_uart_start;

  // Word index must also fit the RAM when DMEM_AW is below the 4 KB window.
  assign w_ram_hit = ((OpResult & RAM_HI_MASK) == 32'h0) &&
                     ((32'(OpResult[11:2]) >> DMEM_AW) == 32'h0);
  assign w_io_hit  = (OpResult[31:8] == IO_BASE);
  assign w_ram_idx = OpResult[DMEM_AW+1:2];
  assign w_off     = OpResult[7:2];

  assign w_wr_io      = MemWrite && w_io_hit;
  assign w_wr_uart    = w_wr_io && (w_off == OFF_UART_DATA);
  assign w_uart_start = w_wr_uart && !w_busy;

  // Combinational load path; unmapped space and write-only registers read 0.
  always_comb begin
    ReadData = 32'h0;
    if (w_ram_hit) begin
      ReadData = r_mem[w_ram_idx];
    end else if (w_io_hit) begin
      case (w_off)
        OFF_LED:       ReadData = 32'(r_led);
        OFF_CYCLE:     ReadData = r_cycle;
        OFF_UART_STAT: ReadData = {30'h0, r_ovr, w_busy};
        default:       ReadData = 32'h0;
      endcase
    end
  end

  // RAM store port; contents are intentionally left unreset.
  always_ff @(posedge CLK) begin
    if (MemWrite && w_ram_hit) begin
      r_mem[w_ram_idx] <= WriteData;
    end
  end

  // LED register, cycle counter (a write clears it) and sticky overrun flag.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_led   <= '0;
      r_cycle <= 32'h0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr_io && (w_off == OFF_LED)) begin
        r_led <= WriteData[LED_W-1:0];
      end
      if (w_wr_io && (w_off == OFF_CYCLE)) begin
        r_cycle <= 32'h0;
      end else begin
        r_cycle <= r_cycle + 32'h1;
      end
      if (w_wr_uart && w_busy) begin
        r_ovr <= 1'b1;
      end else if (w_wr_io && (w_off == OFF_UART_STAT) && WriteData[1]) begin
        r_ovr <= 1'b0;
      end
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .CLK    (CLK),
    .Reset_n(Reset_n),
    .start  (w_uart_start),
    .data   (WriteData[7:0]),
    .tx     (UART_TX),
    .busy   (w_busy)
  );

  assign LED = r_led;

endmodule

// File: doc/dmem_io_bridge.md
Name: dmem_io_bridge

Overview:
- Memory-stage slave of the pipelined ARM core. Consumes the core's MemWrite, OpResult (address) and WriteData, and returns ReadData in the same cycle.
- Decodes the address into three regions: data RAM, a small memory-mapped I/O block, and unmapped space.
- The I/O block contains an LED register, a free-running cycle counter and an 8N1 UART transmitter with status.
- Sits between the core and board pins. Instruction memory is out of scope.

Parameters:
- DMEM_AW, 10, data RAM word-address width (2^DMEM_AW words; 10 gives 4 KB at 0x0000_0000-0x0000_0FFF).
- LED_W, 8, LED register width (1..32).
- CLKS_PER_BIT, 868, UART bit period in CLK cycles (legal range >= 2).

Ports:
- CLK  in  1  core clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store strobe from the core's Mem stage.
- OpResult  in  32  byte address; bits [1:0] ignored (word access only).
- WriteData  in  32  store data.
- ReadData  out  32  load data, combinational from OpResult.
- LED  out  LED_W  LED register contents.
- UART_TX  out  1  serial output; idles high.

Behaviour:
- Decode:
  - RAM region: OpResult[31:12]==0 and word index < 2^DMEM_AW. Word index is OpResult[DMEM_AW+1:2].
  - IO region: OpResult[31:8]==24'hFFFFFF. Offset is OpResult[7:2].
  - All other addresses: ReadData=0, writes ignored.
- RAM:
  - Asynchronous read; write on the rising edge when MemWrite is high.
  - Read and write to the same address in the same cycle returns the old data.
  - RAM contents are not reset.
- IO register map (offsets are byte offsets):
  - 0x00 LED, RW: writes WriteData[LED_W-1:0]; reads are zero-extended.
  - 0x04 CYCLE, RO: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0. A write clears it to 0 at that edge; clear beats increment.
  - 0x08 UART_DATA, WO (reads 0): a write starts transmission of WriteData[7:0] if TX is idle. If busy, the byte is dropped and OVR (sticky) is set.
  - 0x0C UART_STAT: bit0 BUSY (RO), bit1 OVR (write 1 to clear), other bits read 0. If set and clear occur in the same cycle, set wins.
  - Other IO offsets read 0; writes to them are ignored.
- UART TX FSM, states IDLE/START/DATA/STOP:
  - IDLE: UART_TX=1, BUSY=0. An accepted write latches the byte and moves to START at that edge; BUSY=1 from the next cycle.
  - START: UART_TX=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7.
  - STOP: UART_TX=1 for CLKS_PER_BIT cycles, then IDLE. A write in the final STOP cycle is dropped (OVR set).
  - Frame = 10*CLKS_PER_BIT cycles. UART_TX is registered (glitch-free).
- Reset (asynchronous, any time, including mid-frame):
  - LED=0, CYCLE=0, OVR=0, FSM=IDLE, UART_TX=1, BUSY=0. ReadData follows decode immediately.
  - Release takes effect on the next rising edge.
- Latency:
  - Loads: 0 cycles (combinational). Stores: visible on reads from the cycle after the write edge.
  - CYCLE is the exception: it reads the pre-edge value in the write cycle.

Decomposition:
- Shared package dmem_io_pkg holds:
  - region base/mask constants (RAM_HI_MASK, IO_BASE=24'hFFFFFF);
  - IO offsets (OFF_LED=6'h00, OFF_CYCLE=6'h01, OFF_UART_DATA=6'h02, OFF_UART_STAT=6'h03, as word offsets);
  - UART state typedef (IDLE, START, DATA, STOP).
- One sub-module, uart_tx.
  - Ports: CLK, Reset_n, start, data[7:0], tx, busy; parameter CLKS_PER_BIT.
  - The bridge owns decode, RAM, LED, CYCLE and OVR.

Test Plan:
- RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 -> both 0xDEADBEEF. Read 0x0000_2000 -> 0; a write there leaves RAM word 4 unchanged.
- LED/unmapped, LED_W=8: write 0x1234_56A5 to 0xFFFFFF00 -> LED=0xA5, read returns 0x000000A5. Write to 0xFFFFFF40 -> no effect, read 0.
- CYCLE: after reset release, read 0xFFFFFF04 every cycle -> 0,1,2,... Write any value at count 7 -> next read 0. Force 0xFFFFFFFF -> wraps to 0.
- UART, CLKS_PER_BIT=4: write 0xA5 to 0xFFFFFF08 ->
  - UART_TX low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles;
  - STAT bit0=1 for exactly 40 cycles starting the cycle after the write.
- Overrun: second write 0x3C during the frame -> byte not sent, STAT=0x3. Write 0x2 to 0xFFFFFF0C -> STAT bit1=0.
- Reset mid-frame: assert Reset_n=0 during DATA bit 3 -> UART_TX=1, BUSY=0, LED=0, CYCLE=0 immediately. After release, a new write to 0x08 transmits normally.
